pad_gpio_ctrl: RTL and testbench
================================

Name: pad_gpio_ctrl

Overview:
Per-pad GPIO controller sitting directly upstream/downstream of the bidirectional pad cells. Drives each pad cell's IN/OEN (OEN active-low output enable) from registered direction/value/open-drain settings. Consumes the pad cell's OUT through a synchronizer and a per-pad debounce filter, then generates edge-triggered interrupts. Instantiated once in the chip-top pad ring wrapper, between the GPIO register file and the pad cells.

Parameters:
NumPads, 8, number of pads handled
CntWidth, 8, debounce counter/threshold width
SyncStages, 2, flip-flop stages in each input synchronizer (>= 2)

Ports:
clk_i  input  1  core clock
rst_i  input  1  reset, asynchronous, active-high
gpio_out_i  input  NumPads  value to drive per pad
gpio_dir_i  input  NumPads  1 = output, 0 = input
gpio_od_i  input  NumPads  1 = open-drain mode (drive low only)
db_thresh_i  input  CntWidth  debounce threshold in cycles; 0 treated as 1
irq_rise_en_i  input  NumPads  enable pending on rising filtered edge
irq_fall_en_i  input  NumPads  enable pending on falling filtered edge
irq_clr_i  input  NumPads  single-cycle clear pulse per pad
pad_out_i  input  NumPads  from pad cell OUT (raw, asynchronous)
pad_in_o  output  NumPads  to pad cell IN
pad_oen_o  output  NumPads  to pad cell OEN, 0 = drive
gpio_in_o  output  NumPads  debounced pad value
irq_pending_o  output  NumPads  sticky pending flags
irq_o  output  1  OR of irq_pending_o

Behaviour:
- Reset (async, immediate): pad_oen_o = all 1 (all pads tristate), pad_in_o = 0, gpio_in_o = 0, irq_pending_o = 0, irq_o = 0; synchronizers and counters cleared.
- Output path, registered, 1-cycle latency:
  - Push-pull (od=0): pad_in_o = out; pad_oen_o = ~dir.
  - Open-drain (od=1): pad_in_o = 0; pad_oen_o = ~dir | out.
- Input path, per pad:
  - sync = pad_out_i through SyncStages FFs.
  - Stable register st_q drives gpio_in_o; counter cnt_q.
  - If sync == st_q: cnt_q <= 0.
  - Else if cnt_q + 1 >= max(db_thresh_i, 1): st_q <= sync; cnt_q <= 0 (accept event).
  - Else: cnt_q <= cnt_q + 1.
  - Compare is >=, so lowering the threshold mid-count accepts on the next differing cycle. The counter never wraps.
  - A level held for fewer than max(thresh,1) synchronized cycles never reaches gpio_in_o.
- Latency: a level stable at pad_out_i is sampled at edge k and visible on gpio_in_o after edge k + SyncStages + max(thresh,1) - 1, i.e. SyncStages + max(thresh,1) edges inclusive of k.
- Interrupts:
  - Rise event = accept with sync=1; fall event = accept with sync=0.
  - Pending bit sets on an event whose enable is high.
  - irq_clr_i clears the bit at the next edge. Simultaneous set and clear: set wins.
  - Enables gate setting only; clearing an enable leaves an already-pending bit unchanged.
  - irq_o is the combinational OR of pending registers.
- An output-driven pad reads its own value back via pad_out_i; no special handling (normal filter path).
- Reset asserted mid-operation discards partial counts; after release, counting restarts from 0 against st_q = 0.

Decomposition:
- Package pad_gpio_pkg: default CntWidth/SyncStages constants; typedef pad_cfg_t {out, dir, od} per pad; typedef irq_evt_e {EvtNone, EvtRise, EvtFall}.
- Sub-module pad_gpio_filter (one per pad, generate loop): synchronizer, debounce counter, edge/event output. Top holds the output registers and interrupt pending logic.

Test Plan:
1. Assert rst_i asynchronously between edges with pads previously driven -> pad_oen_o=8'hFF, pad_in_o=8'h00, gpio_in_o=0, irq_o=0 immediately, without waiting for a clock edge.
2. dir=8'h01, out=8'h01, od=0 -> one edge later pad_oen_o=8'hFE, pad_in_o=8'h01. Then dir=0 -> pad_oen_o=8'hFF next edge.
3. Open-drain on pad 1: dir[1]=1, od[1]=1, out[1]=1 -> pad_oen_o[1]=1, pad_in_o[1]=0. Then out[1]=0 -> pad_oen_o[1]=0, pad_in_o[1]=0.
4. thresh=4, SyncStages=2: pad_out_i[2] high 3 cycles then low -> gpio_in_o[2] stays 0. High held -> gpio_in_o[2]=1 exactly 6 edges after first sampling edge. thresh=0 -> 3 edges.
5. rise_en[3]=1, fall_en[3]=0, thresh=1: pad 3 rises -> irq_pending_o[3]=1 and irq_o=1 with gpio_in_o[3]. Pad 3 falls -> no change. irq_clr_i[3] coincident with a new rise -> stays 1. Lone clr -> 0 next edge.
6. thresh=10, pad 4 differs for 5 cycles, then thresh changed to 3 -> accept on next differing cycle. Separately, rst_i pulse mid-count (cnt=5) -> after release a full 10-cycle stable level is required to change gpio_in_o[4].

Source files
------------

// File: rtl/pad_gpio_pkg.sv
// Shared types and defaults for the per-pad GPIO controller.
// Holds pad drive configuration, filter event encoding and the pad drive decode.
package pad_gpio_pkg;

  localparam int unsigned DefCntWidth   = 8;
  localparam int unsigned DefSyncStages = 2;

  typedef struct packed {
    logic out;
    logic dir;
    logic od;
  } pad_cfg_t;

  typedef enum logic [1:0] {
    EvtNone = 2'd0,
    EvtRise = 2'd1,
    EvtFall = 2'd2
  } irq_evt_e;

  // Returns {pad IN, pad OEN}; open-drain only ever pulls low, releasing for a 1.
  function automatic logic [1:0] pad_drive(input pad_cfg_t cfg);
    logic in_v;
    logic oen_v;
    if (cfg.od) begin
      in_v  = 1'b0;
      oen_v = ~cfg.dir | cfg.out;
    end else begin
      in_v  = cfg.out;
      oen_v = ~cfg.dir;
    end
    return {in_v, oen_v};
  endfunction

endpackage

// File: rtl/pad_gpio_filter.sv
// One pad's input path: synchronizer, debounce filter and accepted-edge event.
// The event is combinational so interrupt pending updates on the same edge as the level.
module pad_gpio_filter
  import pad_gpio_pkg::*;
#(
  parameter int unsigned CntWidth   = DefCntWidth,
  parameter int unsigned SyncStages = DefSyncStages
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pad_i,
  input  logic [CntWidth-1:0] thresh_i,
  output logic                level_o,
  output irq_evt_e            evt_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  sync_bit;
  logic                  st_q, st_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [CntWidth:0]     thr_eff;
  logic [CntWidth:0]     cnt_inc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      st_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pad_i};
      st_q   <= st_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sync_bit = sync_q[SyncStages-1];

  // One extra bit keeps cnt+1 from wrapping before the compare.
  always_comb begin
    thr_eff = (thresh_i == '0) ? {{CntWidth{1'b0}}, 1'b1} : {1'b0, thresh_i};
    cnt_inc = {1'b0, cnt_q} + {{CntWidth{1'b0}}, 1'b1};
    st_d    = st_q;
    cnt_d   = cnt_q;
    evt_o   = EvtNone;
    if (sync_bit == st_q) begin
      cnt_d = '0;
    end else if (cnt_inc >= thr_eff) begin
      st_d  = sync_bit;
      cnt_d = '0;
      evt_o = sync_bit ? EvtRise : EvtFall;
    end else begin
      cnt_d = cnt_inc[CntWidth-1:0];
    end
  end

  assign level_o = st_q;

endmodule

// File: rtl/pad_gpio_ctrl.sv
// Per-pad GPIO controller: registered pad drive, debounced pad readback and
// sticky edge interrupts, placed between the GPIO register file and the pad cells.
module pad_gpio_ctrl
  import pad_gpio_pkg::*;
#(
  parameter int unsigned NumPads    = 8,
  parameter int unsigned CntWidth   = DefCntWidth,
  parameter int unsigned SyncStages = DefSyncStages
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumPads-1:0]  gpio_out_i,
  input  logic [NumPads-1:0]  gpio_dir_i,
  input  logic [NumPads-1:0]  gpio_od_i,
  input  logic [CntWidth-1:0] db_thresh_i,
  input  logic [NumPads-1:0]  irq_rise_en_i,
  input  logic [NumPads-1:0]  irq_fall_en_i,
  input  logic [NumPads-1:0]  irq_clr_i,
  input  logic [NumPads-1:0]  pad_out_i,
  output logic [NumPads-1:0]  pad_in_o,
  output logic [NumPads-1:0]  pad_oen_o,
  output logic [NumPads-1:0]  gpio_in_o,
  output logic [NumPads-1:0]  irq_pending_o,
  output logic                irq_o
);

  logic [NumPads-1:0] pad_in_q, pad_in_d;
  logic [NumPads-1:0] pad_oen_q, pad_oen_d;
  logic [NumPads-1:0] pend_q, pend_d;
  logic [NumPads-1:0] evt_set;
  irq_evt_e           evt [NumPads];

  always_comb begin
    pad_in_d  = '0;
    pad_oen_d = '1;
    for (int i = 0; i < NumPads; i++) begin
      pad_cfg_t   cfg;
      logic [1:0] drv;
      cfg.out      = gpio_out_i[i];
      cfg.dir      = gpio_dir_i[i];
      cfg.od       = gpio_od_i[i];
      drv          = pad_drive(cfg);
      pad_in_d[i]  = drv[1];
      pad_oen_d[i] = drv[0];
    end
  end

  for (genvar g = 0; g < NumPads; g++) begin : g_filt
    pad_gpio_filter #(
      .CntWidth   (CntWidth),
      .SyncStages (SyncStages)
    ) u_filt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .pad_i    (pad_out_i[g]),
      .thresh_i (db_thresh_i),
      .level_o  (gpio_in_o[g]),
      .evt_o    (evt[g])
    );
  end

  // Set has priority over a coincident clear.
  always_comb begin
    evt_set = '0;
    for (int i = 0; i < NumPads; i++) begin
      evt_set[i] = ((evt[i] == EvtRise) && irq_rise_en_i[i]) ||
                   ((evt[i] == EvtFall) && irq_fall_en_i[i]);
    end
    pend_d = (pend_q & ~irq_clr_i) | evt_set;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pad_in_q  <= '0;
      pad_oen_q <= '1;
      pend_q    <= '0;
    end else begin
      pad_in_q  <= pad_in_d;
      pad_oen_q <= pad_oen_d;
      pend_q    <= pend_d;
    end
  end

  assign pad_in_o      = pad_in_q;
  assign pad_oen_o     = pad_oen_q;
  assign irq_pending_o = pend_q;
  assign irq_o         = |pend_q;

endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// Directed bench for pad_gpio_ctrl with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pad_gpio_ctrl;

  localparam int unsigned NumPads  = 8;
  localparam int unsigned CntWidth = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NumPads-1:0]  gpio_out, gpio_dir, gpio_od;
  logic [CntWidth-1:0] db_thresh;
  logic [NumPads-1:0]  rise_en, fall_en, clr;
  logic [NumPads-1:0]  pad_out;
  logic [NumPads-1:0]  pad_in, pad_oen, gpio_in, pending;
  logic                irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pad_gpio_ctrl #(
    .NumPads    (NumPads),
    .CntWidth   (CntWidth),
    .SyncStages (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .gpio_out_i    (gpio_out),
    .gpio_dir_i    (gpio_dir),
    .gpio_od_i     (gpio_od),
    .db_thresh_i   (db_thresh),
    .irq_rise_en_i (rise_en),
    .irq_fall_en_i (fall_en),
    .irq_clr_i     (clr),
    .pad_out_i     (pad_out),
    .pad_in_o      (pad_in),
    .pad_oen_o     (pad_oen),
    .gpio_in_o     (gpio_in),
    .irq_pending_o (pending),
    .irq_o         (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    gpio_out  = '0;
    gpio_dir  = '0;
    gpio_od   = '0;
    db_thresh = 8'd1;
    rise_en   = '0;
    fall_en   = '0;
    clr       = '0;
    pad_out   = '0;
    #1;
    check("por_oen", 32'(pad_oen), 32'hFF);
    check("por_in", 32'(pad_in), 32'h00);
    #11 rst = 1'b0;
    tick(1);

    // Drive everything, get filtered levels and a pending bit, then async reset.
    gpio_dir = 8'hFF; gpio_out = 8'hFF; pad_out = 8'hFF; rise_en = 8'h01;
    tick(4);
    check("pre_oen", 32'(pad_oen), 32'h00);
    check("pre_gin", 32'(gpio_in), 32'hFF);
    check("pre_irq", 32'(irq), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_oen", 32'(pad_oen), 32'hFF);
    check("arst_in", 32'(pad_in), 32'h00);
    check("arst_gin", 32'(gpio_in), 32'h00);
    check("arst_pend", 32'(pending), 32'h00);
    check("arst_irq", 32'(irq), 32'h0);
    gpio_dir = '0; gpio_out = '0; pad_out = '0; rise_en = '0;
    tick(1);
    rst = 1'b0;
    tick(1);

    // Push-pull drive with one-cycle register latency.
    gpio_dir = 8'h01; gpio_out = 8'h01;
    #1;
    check("pp_oen_before_edge", 32'(pad_oen), 32'hFF);
    tick(1);
    check("pp_oen", 32'(pad_oen), 32'hFE);
    check("pp_in", 32'(pad_in), 32'h01);
    gpio_dir = 8'h00;
    tick(1);
    check("pp_oen_off", 32'(pad_oen), 32'hFF);

    // Open-drain on pad 1.
    gpio_dir = 8'h02; gpio_od = 8'h02; gpio_out = 8'h02;
    tick(1);
    check("od_high_oen", 32'(pad_oen), 32'hFF);
    check("od_high_in", 32'(pad_in), 32'h00);
    gpio_out = 8'h00;
    tick(1);
    check("od_low_oen", 32'(pad_oen), 32'hFD);
    check("od_low_in", 32'(pad_in), 32'h00);
    gpio_dir = '0; gpio_od = '0;

    // Debounce, thresh=4: a 3-cycle glitch is rejected.
    db_thresh = 8'd4;
    pad_out[2] = 1'b1;
    tick(3);
    pad_out[2] = 1'b0;
    tick(8);
    check("glitch_rejected", 32'(gpio_in[2]), 32'h0);
    // Held high: visible exactly 6 edges after the first sampling edge.
    pad_out[2] = 1'b1;
    tick(5);
    check("db4_edge5", 32'(gpio_in[2]), 32'h0);
    tick(1);
    check("db4_edge6", 32'(gpio_in[2]), 32'h1);
    // thresh=0 behaves as 1: 3 edges.
    db_thresh = 8'd0;
    pad_out[2] = 1'b0;
    tick(2);
    check("db0_edge2", 32'(gpio_in[2]), 32'h1);
    tick(1);
    check("db0_edge3", 32'(gpio_in[2]), 32'h0);

    // Interrupts on pad 3, rise only.
    db_thresh = 8'd1; rise_en = 8'h08; fall_en = 8'h00;
    pad_out[3] = 1'b1;
    tick(2);
    check("rise_pend_early", 32'(pending), 32'h00);
    tick(1);
    check("rise_pend", 32'(pending), 32'h08);
    check("rise_irq", 32'(irq), 32'h1);
    check("rise_gin", 32'(gpio_in[3]), 32'h1);
    pad_out[3] = 1'b0;
    tick(3);
    check("fall_gin", 32'(gpio_in[3]), 32'h0);
    check("fall_no_change", 32'(pending), 32'h08);
    pad_out[3] = 1'b1;
    tick(2);
    clr = 8'h08;
    tick(1);
    clr = 8'h00;
    check("set_beats_clr_gin", 32'(gpio_in[3]), 32'h1);
    check("set_beats_clr", 32'(pending), 32'h08);
    rise_en = 8'h00;
    tick(1);
    check("en_off_keeps", 32'(pending), 32'h08);
    clr = 8'h08;
    tick(1);
    clr = 8'h00;
    check("clr_pend", 32'(pending), 32'h00);
    check("clr_irq", 32'(irq), 32'h0);

    // Lowering the threshold mid-count accepts on the next differing cycle.
    db_thresh = 8'd10;
    pad_out[4] = 1'b1;
    tick(7);
    check("thr10_cnt5", 32'(gpio_in[4]), 32'h0);
    db_thresh = 8'd3;
    tick(1);
    check("thr_lowered", 32'(gpio_in[4]), 32'h1);

    // Bring pad 4 back to 0, then reset mid-count discards the partial count.
    db_thresh = 8'd1;
    pad_out[4] = 1'b0;
    tick(3);
    check("p4_low", 32'(gpio_in[4]), 32'h0);
    db_thresh = 8'd10;
    pad_out[4] = 1'b1;
    tick(7);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick(11);
    check("rst_recount_11", 32'(gpio_in[4]), 32'h0);
    tick(1);
    check("rst_recount_12", 32'(gpio_in[4]), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
